i2s_source_arbiter: RTL and testbench

- Generates the one-hot `i2s_select[3:0]` that steers the ADV7664 tile (0..3) I2S mux toward the DSP; sits directly upstream of that mux.
- Monitors each tile's `sclk` for activity in the system clock domain and picks a source by fixed priority or manual override.
- Inserts a muted gap (`select = 0`, which drives the mux outputs low) on every source change, so the DSP never sees two sources spliced together.

---
 rtl/i2s_source_arbiter.sv | 168 ++++++++++++++++
 tb/tb_i2s_source_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_source_arbiter.sv
// I2S source arbiter: picks one ADV7664 tile by sclk activity, inserting a muted gap on every change.
// Optional build macro I2S_SRC_STICKY_EN keeps the current source while it stays active.
module i2s_source_arbiter #(
    parameter int WINDOW_CYCLES = 1024,
    parameter int MIN_EDGES     = 16,
    parameter int MUTE_CYCLES   = 256,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] adv_sclk,
    input  logic       force_en,
    input  logic [1:0] force_sel,
    output logic [3:0] i2s_select,
    output logic [3:0] active_mask,
    output logic       switch_pulse
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUTE = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;

    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_E     = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0] MUTE_LOAD = CNT_W'(MUTE_CYCLES - 1);

    logic [3:0]       r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_win;
    logic [CNT_W-1:0] r_edge [4];
    logic [3:0]       r_mask;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_mute;
    logic [1:0]       r_cur;
    logic [3:0]       r_sel;
    logic             r_pulse;

    logic [3:0]       w_edge;
    logic             w_term;
    logic [1:0]       w_tgt;
    logic             w_tgt_vld;
    logic             w_keep;
    logic [1:0]       w_nstate;
    logic [1:0]       w_ncur;
    logic [CNT_W-1:0] w_nmute;
    logic             w_npulse;
    logic [3:0]       w_nsel;

    assign w_edge = r_s2 & ~r_s3;
    assign w_term = (r_win == WIN_LAST);

    // sclk is asynchronous: two-flop synchronizer plus one flop for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 4'b0;
            r_s2 <= 4'b0;
            r_s3 <= 4'b0;
        end else begin
            r_s1 <= adv_sclk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win  <= '0;
            r_mask <= 4'b0;
            for (int i = 0; i < 4; i++) begin
                r_edge[i] <= '0;
            end
        end else begin
            r_win <= w_term ? '0 : r_win + 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (w_term) begin
                    r_mask[i] <= (r_edge[i] + CNT_W'(w_edge[i])) >= MIN_E;
                    r_edge[i] <= '0;
                end else if (w_edge[i] && (r_edge[i] < MIN_E)) begin
                    r_edge[i] <= r_edge[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_tgt     = 2'd0;
        w_tgt_vld = 1'b0;
        if (force_en) begin
            w_tgt     = force_sel;
            w_tgt_vld = 1'b1;
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (r_mask[i]) begin
                    w_tgt = 2'(i);
                end
            end
            w_tgt_vld = |r_mask;
        end
    end

`ifdef I2S_SRC_STICKY_EN
    assign w_keep = !force_en && r_mask[r_cur];
`else
    assign w_keep = 1'b0;
`endif

    always_comb begin
        w_nstate = r_state;
        w_ncur   = r_cur;
        w_nmute  = r_mute;
        w_npulse = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_tgt_vld) begin
                    w_nstate = S_MUTE;
                    w_nmute  = MUTE_LOAD;
                end
            end
            S_MUTE: begin
                if (r_mute == '0) begin
                    if (w_tgt_vld) begin
                        w_nstate = S_ON;
                        w_ncur   = w_tgt;
                        w_npulse = 1'b1;
                    end else begin
                        w_nstate = S_IDLE;
                    end
                end else begin
                    w_nmute = r_mute - 1'b1;
                end
            end
            S_ON: begin
                if (w_keep) begin
                    w_nstate = S_ON;
                end else if (!w_tgt_vld) begin
                    w_nstate = S_IDLE;
                end else if (w_tgt != r_cur) begin
                    w_nstate = S_MUTE;
                    w_nmute  = MUTE_LOAD;
                end
            end
            default: begin
                w_nstate = S_IDLE;
            end
        endcase
        w_nsel = (w_nstate == S_ON) ? (4'b0001 << w_ncur) : 4'b0000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mute  <= '0;
            r_cur   <= 2'd0;
            r_sel   <= 4'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_mute  <= w_nmute;
            r_cur   <= w_ncur;
            r_sel   <= w_nsel;
            r_pulse <= w_npulse;
        end
    end

    assign i2s_select   = r_sel;
    assign active_mask  = r_mask;
    assign switch_pulse = r_pulse;

endmodule

// File: tb/tb_i2s_source_arbiter.sv
// Randomized bench for i2s_source_arbiter against a behavioural reference model.
// Build with I2S_SRC_STICKY_EN defined to exercise the sticky variant.
module tb_i2s_source_arbiter;

    localparam int WIN  = 64;
    localparam int MINE = 4;
    localparam int MUTE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] adv_sclk = 4'b0;
    logic       force_en = 1'b0;
    logic [1:0] force_sel = 2'd0;
    logic [3:0] i2s_select;
    logic [3:0] active_mask;
    logic       switch_pulse;

    i2s_source_arbiter #(
        .WINDOW_CYCLES(WIN),
        .MIN_EDGES    (MINE),
        .MUTE_CYCLES  (MUTE),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .adv_sclk    (adv_sclk),
        .force_en    (force_en),
        .force_sel   (force_sel),
        .i2s_select  (i2s_select),
        .active_mask (active_mask),
        .switch_pulse(switch_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef enum {IDLE, MUTING, PLAYING} mode_t;

    logic [3:0] hist[$];
    int         ecount[4];
    logic [3:0] m_mask;
    mode_t      mode;
    int         cur;
    longint     on_at;
    longint     tick;
    logic [3:0] m_sel;
    logic       m_pulse;
    logic [3:0] prev_sel;
    int         npulse;

    int half[4];
    int phase_cnt[4];

    task automatic model_reset();
        hist = '{4'b0, 4'b0, 4'b0};
        for (int i = 0; i < 4; i++) ecount[i] = 0;
        m_mask  = 4'b0;
        mode    = IDLE;
        cur     = 0;
        on_at   = 0;
        tick    = 0;
        m_sel   = 4'b0;
        m_pulse = 1'b0;
    endtask

    function automatic int target();
        if (force_en) return int'(force_sel);
        for (int i = 0; i < 4; i++) begin
            if (m_mask[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clock();
        int t;
        logic [3:0] strobe;
        logic keep;
        if (rst) begin
            model_reset();
            return;
        end
        t = target();
        strobe = hist[1] & ~hist[2];
        m_pulse = 1'b0;
        keep = 1'b0;
        case (mode)
            IDLE: if (t >= 0) begin
                mode  = MUTING;
                on_at = tick + MUTE;
            end
            MUTING: if (tick == on_at) begin
                if (t >= 0) begin
                    mode    = PLAYING;
                    cur     = t;
                    m_pulse = 1'b1;
                end else begin
                    mode = IDLE;
                end
            end
            PLAYING: begin
`ifdef I2S_SRC_STICKY_EN
                keep = !force_en && m_mask[cur];
`endif
                if (!keep) begin
                    if (t < 0) begin
                        mode = IDLE;
                    end else if (t != cur) begin
                        mode  = MUTING;
                        on_at = tick + MUTE;
                    end
                end
            end
            default: mode = IDLE;
        endcase
        m_sel = (mode == PLAYING) ? 4'(1 << cur) : 4'b0;
        if ((tick % WIN) == WIN - 1) begin
            for (int i = 0; i < 4; i++) begin
                m_mask[i] = (ecount[i] + int'(strobe[i])) >= MINE;
                ecount[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) ecount[i] += int'(strobe[i]);
        end
        hist.push_front(adv_sclk);
        void'(hist.pop_back());
        tick++;
    endtask

    task automatic drive_pins();
        for (int i = 0; i < 4; i++) begin
            if (half[i] == 0) begin
                adv_sclk[i] = 1'b0;
                phase_cnt[i] = 0;
            end else begin
                phase_cnt[i]++;
                if (phase_cnt[i] >= half[i]) begin
                    adv_sclk[i] = ~adv_sclk[i];
                    phase_cnt[i] = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        chk("sel", i2s_select, m_sel);
        chk("mask", active_mask, m_mask);
        chk("pulse", switch_pulse, m_pulse);
        chk("onehot", $countones(i2s_select) <= 1, 1);
        if (prev_sel != 4'b0 && i2s_select != 4'b0)
            chk("splice", i2s_select, prev_sel);
        if (switch_pulse) npulse++;
        prev_sel = i2s_select;
        drive_pins();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 4; i++) begin
            half[i] = 0;
            phase_cnt[i] = 0;
        end
        prev_sel = 4'b0;
        npulse = 0;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_sel", i2s_select, 4'b0);
        chk("rst_mask", active_mask, 4'b0);
        chk("rst_pulse", switch_pulse, 1'b0);
        run(3);
        rst = 1'b0;

        run(500);
        chk("quiet_sel", i2s_select, 4'b0000);
        chk("quiet_mask", active_mask, 4'b0000);
        chk("quiet_pulses", npulse, 0);

        npulse = 0;
        half[2] = 4;
        run(3 * WIN);
        chk("t2_mask", active_mask, 4'b0100);
        chk("t2_sel", i2s_select, 4'b0100);
        chk("t2_pulses", npulse, 1);

        half[0] = 3;
        run(4 * WIN);
`ifdef I2S_SRC_STICKY_EN
        chk("t0_sel", i2s_select, 4'b0100);
`else
        chk("t0_sel", i2s_select, 4'b0001);
`endif

        half[0] = 0;
        run(4 * WIN);
        chk("t0off_mask", active_mask, 4'b0100);
        chk("t0off_sel", i2s_select, 4'b0100);

        half[2] = 0;
        run(3 * WIN);
        chk("none_sel", i2s_select, 4'b0000);
        force_en = 1'b1;
        force_sel = 2'd3;
        run(12);
        chk("force_sel", i2s_select, 4'b1000);
        force_en = 1'b0;
        run(1);
        chk("unforce_sel", i2s_select, 4'b0000);

        half[1] = 5;
        guard = 0;
        while (mode != MUTING && guard < 300) begin
            step();
            guard++;
        end
        chk("reach_mute", mode == MUTING, 1);
        run(2);
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_sel", i2s_select, 4'b0);
        chk("midrst_mask", active_mask, 4'b0);
        chk("midrst_pulse", switch_pulse, 1'b0);
        run(3);
        rst = 1'b0;
        run(4 * WIN);
        chk("t1_sel", i2s_select, 4'b0010);

        for (int seg = 0; seg < 30; seg++) begin
            for (int i = 0; i < 4; i++) begin
                half[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 14));
            end
            force_en  = ($urandom_range(0, 3) == 0);
            force_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                chk("rnd_rst_sel", i2s_select, 4'b0);
                run(2);
                rst = 1'b0;
            end
            run(int'($urandom_range(20, 150)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
